// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit and the instruction decoder.
// Holds op select encodings, sequencer state encodings and the default datapath width.
// Helper functions classify an op as divide and/or signed.
package muldiv_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W     = 6;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    function automatic logic op_is_div(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU);
    endfunction

    function automatic logic op_is_signed(input op_e o);
        return (o == OP_MULT) || (o == OP_DIV);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration on the {hi,lo} working register: shift-add multiply or restoring divide.
// Purely combinational, zero latency.
// No flow control; the sequencer decides when the result is captured.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] acc_out
);

    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             fits;

    // Multiply: add multiplicand when the multiplier LSB is set, then shift right with carry.
    // Divide: shift the partial remainder left, subtract the divisor if it fits, record a quotient bit.
    always_comb begin
        acc_hi  = acc_in[2*WIDTH-1:WIDTH];
        acc_lo  = acc_in[WIDTH-1:0];
        mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
        rem_sh  = {acc_hi, acc_lo[WIDTH-1]};
        fits    = (rem_sh >= {1'b0, operand});
        if (is_div) begin
            // After a successful subtract the remainder is below the divisor, so WIDTH bits suffice.
            if (fits) begin
                acc_out = {rem_sh[WIDTH-1:0] - operand, acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                acc_out = {rem_sh[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_out = {mul_sum, acc_lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS-style HI/LO multiply/divide unit with mthi/mtlo moves.
// Latency: start sampled at edge k, done pulse and new HI/LO in the cycle after edge k+33.
// Backpressure: busy stalls upstream; start and moves are ignored while busy.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] mt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

    state_e             state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0]   operand_q;
    logic               is_div_q;
    logic               neg_main_q;   // sign of product, or of quotient
    logic               neg_rem_q;    // sign of remainder (dividend sign)
    logic               dz_q;

    op_e                op_in;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // Operand magnitudes and signs captured when an operation is accepted.
    always_comb begin
        op_in = op_e'(op);
        a_neg = op_is_signed(op_in) & src_a[WIDTH-1];
        b_neg = op_is_signed(op_in) & src_b[WIDTH-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
    end

    // Sign correction of the unsigned iteration result; divide-by-zero forces an all-ones quotient.
    // The remainder of a zero divide is |a| re-signed, which reproduces src_a exactly.
    always_comb begin
        prod_fix = neg_main_q ? -acc_q : acc_q;
        quo      = acc_q[WIDTH-1:0];
        rem      = acc_q[2*WIDTH-1:WIDTH];
        if (is_div_q) begin
            fix_lo = dz_q ? {WIDTH{1'b1}} : (neg_main_q ? -quo : quo);
            fix_hi = neg_rem_q ? -rem : rem;
        end else begin
            fix_lo = prod_fix[WIDTH-1:0];
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
        end
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .operand (operand_q),
        .acc_out (acc_nxt)
    );

    // Control FSM: accept start or moves in IDLE, iterate in CALC, commit HI/LO in FIX.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            acc_q      <= '0;
            operand_q  <= '0;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            dz_q       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            div_zero   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        // Start has priority over a simultaneous move.
                        is_div_q   <= op_is_div(op_in);
                        neg_main_q <= a_neg ^ b_neg;
                        neg_rem_q  <= a_neg;
                        dz_q       <= op_is_div(op_in) && (src_b == '0);
                        if (op_is_div(op_in)) begin
                            acc_q     <= {{WIDTH{1'b0}}, a_mag};
                            operand_q <= b_mag;
                        end else begin
                            acc_q     <= {{WIDTH{1'b0}}, b_mag};
                            operand_q <= a_mag;
                        end
                        cnt      <= CNT_LOAD;
                        div_zero <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_CALC;
                    end else begin
                        if (mthi) hi <= mt_data;
                        if (mtlo) lo <= mt_data;
                    end
                end
                ST_CALC: begin
                    acc_q <= acc_nxt;
                    cnt   <= cnt - CNT_LAST;
                    if (cnt == CNT_LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    if (dz_q) div_zero <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus pushes expected HI/LO/div_zero and issue edge,
// a negedge monitor pops on every done pulse and checks values and latency.
// Directed vectors plus a short reference-model regression.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] src_a;
    logic [W-1:0] src_b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] mt_data;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         div_zero;

    muldiv_sequencer #(.WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .mt_data  (mt_data),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo),
        .div_zero (div_zero)
    );

    always #5 clock = ~clock;

    int edge_cnt = 0;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           k;
        string        name;
    } exp_t;

    exp_t scb[$];
    exp_t mon_e;
    int   checks = 0;
    int   passes = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // Monitor: every done pulse must match the oldest outstanding operation, 33 edges after issue.
    always @(negedge clock) begin
        if (done === 1'b1) begin
            if (scb.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                mon_e = scb.pop_front();
                check({mon_e.name, "_hi"}, hi, mon_e.hi);
                check({mon_e.name, "_lo"}, lo, mon_e.lo);
                check({mon_e.name, "_div_zero"}, div_zero, mon_e.dz);
                check({mon_e.name, "_latency"}, edge_cnt, mon_e.k + 33);
            end
        end
    end

    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input string nm);
        exp_t   e;
        longint sp;
        longint unsigned up;
        int     sa;
        int     sbv;
        e.name = nm;
        e.k    = 0;
        e.dz   = 1'b0;
        e.hi   = '0;
        e.lo   = '0;
        case (o)
            2'b00: begin
                sp   = longint'($signed(a)) * longint'($signed(b));
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            2'b01: begin
                up   = {32'b0, a} * {32'b0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == '0) begin
                    e.dz = 1'b1;
                    e.lo = '1;
                    e.hi = a;
                end else if (o == 2'b10) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000;
                        e.hi = '0;
                    end else begin
                        sa   = a;
                        sbv  = b;
                        e.lo = sa / sbv;
                        e.hi = sa % sbv;
                    end
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) check("idle_timeout", busy, 1'b0);
    endtask

    // Present start for one sampling edge and record the expected completion.
    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e);
        exp_t x;
        x     = e;
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(posedge clock);
        #1;
        x.k   = edge_cnt;
        scb.push_back(x);
        start = 1'b0;
        op    = 2'bxx;
        src_a = 'x;
        src_b = 'x;
        check({x.name, "_busy_after_start"}, busy, 1'b1);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] ehi, input logic [W-1:0] elo, input logic edz,
                          input string nm);
        exp_t e;
        e.hi = ehi;
        e.lo = elo;
        e.dz = edz;
        e.k  = 0;
        e.name = nm;
        wait_idle();
        issue(o, a, b, e);
    endtask

    typedef struct {
        logic [1:0]   o;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] ehi;
        logic [W-1:0] elo;
        logic         edz;
        string        nm;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        int   k0;
        int   n;
        exp_t e;
        logic [1:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset   = 1'b1;
        start   = 1'b0;
        op      = 2'b00;
        src_a   = '0;
        src_b   = '0;
        mthi    = 1'b0;
        mtlo    = 1'b0;
        mt_data = '0;
        repeat (3) tick();
        reset = 1'b0;

        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_hi", hi, '0);
        check("reset_lo", lo, '0);
        check("reset_div_zero", div_zero, 1'b0);

        // Direct moves in IDLE.
        mthi = 1'b1; mt_data = 32'h1234_5678;
        tick();
        mthi = 1'b0;
        check("mthi_hi", hi, 32'h1234_5678);
        mtlo = 1'b1; mt_data = 32'h9ABC_DEF0;
        tick();
        mtlo = 1'b0;
        check("mtlo_lo", lo, 32'h9ABC_DEF0);
        check("mtlo_keeps_hi", hi, 32'h1234_5678);

        // Start with a simultaneous move: start wins. Then hold, ignored start and ignored moves.
        mthi = 1'b1; mt_data = 32'h0000_DEAD;
        run_op(2'b01, 32'd2, 32'd3, 32'h0, 32'h6, 1'b0, "multu_2x3_with_mthi");
        mthi = 1'b0;
        repeat (3) tick();
        check("hold_hi_in_calc", hi, 32'h1234_5678);
        check("hold_lo_in_calc", lo, 32'h9ABC_DEF0);
        tick();
        start = 1'b1; op = 2'b11; src_a = 32'd99; src_b = 32'd5;
        tick();
        start = 1'b0;
        repeat (4) tick();
        mthi = 1'b1; mtlo = 1'b1; mt_data = 32'h0000_1234;
        tick();
        mthi = 1'b0; mtlo = 1'b0;
        check("busy_mid_op", busy, 1'b1);
        check("mthi_ignored_busy", hi, 32'h1234_5678);

        // Directed vectors, hand-computed.
        vecs.push_back('{2'b00, 32'hFFFF_FFFE, 32'h3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, "mult_m2x3"});
        vecs.push_back('{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7_2"});
        vecs.push_back('{2'b11, 32'h7,         32'h0,         32'h0000_0007, 32'hFFFF_FFFF, 1'b1, "divu_7_0"});
        vecs.push_back('{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1'b0, "div_ovf"});
        vecs.push_back('{2'b00, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0,         32'h0000_002A, 1'b0, "mult_m7xm6"});
        vecs.push_back('{2'b10, 32'h7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7_m2"});
        vecs.push_back('{2'b11, 32'd100,       32'd7,         32'h0000_0002, 32'h0000_000E, 1'b0, "divu_100_7"});
        vecs.push_back('{2'b01, 32'h8000_0000, 32'h2,         32'h0000_0001, 32'h0,         1'b0, "multu_2p32"});
        vecs.push_back('{2'b10, 32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1, "div_m7_0"});
        vecs.push_back('{2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000, 1'b0, "mult_maxxmin"});
        foreach (vecs[i]) begin
            run_op(vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].ehi, vecs[i].elo, vecs[i].edz, vecs[i].nm);
        end

        // Back-to-back: second start presented in the done cycle of the first.
        run_op(2'b01, 32'd6, 32'd7, 32'h0, 32'd42, 1'b0, "b2b_first");
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (n >= 100) check("b2b_done_timeout", done, 1'b1);
        e.hi = 32'h0000_0001; e.lo = 32'h0000_0003; e.dz = 1'b0; e.k = 0; e.name = "b2b_second";
        issue(2'b11, 32'd10, 32'd3, e);

        // Reset mid-operation: abandon, clear, and no done afterwards.
        wait_idle();
        run_op(2'b01, 32'd1000, 32'd1000, 32'h0, 32'd1000000, 1'b0, "reset_victim");
        k0 = edge_cnt;
        while (edge_cnt < k0 + 19) tick();
        reset = 1'b1;
        scb.delete();
        tick();
        reset = 1'b0;
        check("midreset_busy", busy, 1'b0);
        check("midreset_hi", hi, '0);
        check("midreset_lo", lo, '0);
        check("midreset_done", done, 1'b0);
        while (edge_cnt < k0 + 40) tick();

        // Short regression against the reference model.
        for (int i = 0; i < 20; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom();
            rb = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom();
            if (i % 4 == 1) rb = rb >> $urandom_range(8, 28);
            e  = model(ro, ra, rb, $sformatf("rand%0d_op%0d", i, ro));
            run_op(ro, ra, rb, e.hi, e.lo, e.dz, e.name);
        end

        wait_idle();
        repeat (3) tick();
        check("scoreboard_drained", scb.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
